display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_pkg.sv | 18 +
 rtl/bcd_to_7seg.sv | 26 ++
 rtl/display_scan.sv | 101 ++++++++++
 tb/tb_display_scan.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and glyph constants for the multiplexed 7-segment display scanner.
package display_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned BCD_W = 4;

    typedef logic [SEG_W-1:0] seg_t;   // {g,f,e,d,c,b,a}, active-low
    typedef logic [BCD_W-1:0] bcd_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_DASH  = 7'b0111111;

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 render a dash.
module bcd_to_7seg
    import display_pkg::*;
(
    input  bcd_t i_bcd,
    output seg_t o_seg_c
);

    always_comb begin
        o_seg_c = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg_c = 7'b1000000;
            4'd1:    o_seg_c = 7'b1111001;
            4'd2:    o_seg_c = 7'b0100100;
            4'd3:    o_seg_c = 7'b0110000;
            4'd4:    o_seg_c = 7'b0011001;
            4'd5:    o_seg_c = 7'b0010010;
            4'd6:    o_seg_c = 7'b0000010;
            4'd7:    o_seg_c = 7'b1111000;
            4'd8:    o_seg_c = 7'b0000000;
            4'd9:    o_seg_c = 7'b0010000;
            default: o_seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed BCD display scanner with frame-coherent shadow registers.
// Optional leading-zero blanking: define DISPLAY_LEADING_ZERO_BLANK_EN.
module display_scan
    import display_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BCD_W*DIGITS-1:0] digits,
    input  logic [DIGITS-1:0]       dp_in,
    output seg_t                    seg,
    output logic                    dp,
    output logic [DIGITS-1:0]       an
);

    localparam int unsigned CNT_W = cnt_width(SCAN_DIV);
    localparam int unsigned IDX_W = cnt_width(DIGITS);

    logic [CNT_W-1:0]        r_scan_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [BCD_W*DIGITS-1:0] r_shadow;
    logic [DIGITS-1:0]       r_shadow_dp;
    seg_t                    r_seg;
    logic                    r_dp;
    logic [DIGITS-1:0]       r_an;

    logic                    w_cnt_wrap;
    logic                    w_idx_last;
    bcd_t                    w_sel_bcd;
    seg_t                    w_dec_seg;
    logic [DIGITS-1:0]       w_blank;

    assign w_cnt_wrap = (r_scan_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_idx_last = (r_idx == IDX_W'(DIGITS - 1));
    assign w_sel_bcd  = r_shadow[BCD_W*r_idx +: BCD_W];

    // Slot timing: scan_cnt paces each digit, idx walks the digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else begin
            r_scan_cnt <= w_cnt_wrap ? '0 : r_scan_cnt + CNT_W'(1);
            if (w_cnt_wrap) begin
                r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    // Shadows only update on the last cycle of a frame so a frame is never torn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow    <= '0;
            r_shadow_dp <= '0;
        end else if (w_cnt_wrap && w_idx_last) begin
            r_shadow    <= digits;
            r_shadow_dp <= dp_in;
        end
    end

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    logic w_run;

    // A digit blanks while it and every more significant digit are zero; digit 0 never blanks.
    always_comb begin
        w_blank = '0;
        w_run   = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_run      = w_run && (r_shadow[BCD_W*i +: BCD_W] == '0);
            w_blank[i] = w_run;
        end
    end
`else
    assign w_blank = '0;
`endif

    bcd_to_7seg u_dec (
        .i_bcd   (w_sel_bcd),
        .o_seg_c (w_dec_seg)
    );

    // Output stage: one clk behind idx, blank while reset is asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
            r_an  <= '1;
        end else begin
            r_seg <= w_blank[r_idx] ? SEG_BLANK : w_dec_seg;
            r_dp  <= ~r_shadow_dp[r_idx];
            r_an  <= ~(DIGITS'(1) << r_idx);
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp;
    assign an  = r_an;

endmodule

// File: tb/tb_display_scan.sv
// Randomized self-checking bench for display_scan (DIGITS=4, SCAN_DIV=4) against a frame-level model.
module tb_display_scan;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned FRAME    = DIGITS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Model state: cycles since reset release and the digits latched at the last frame end.
    int unsigned m_n   = 0;
    int unsigned m_sh  = 0;
    logic [3:0]  m_psh = '0;

    display_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .digits (digits),
        .dp_in  (dp_in),
        .seg    (seg),
        .dp     (dp),
        .an     (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int unsigned v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Drive inputs, take one edge, and compare {an,seg,dp} with the model.
    task automatic tick(input logic [15:0] d, input logic [3:0] p, input logic r);
        logic [31:0] expv;
        int unsigned slot;
        logic [6:0]  segv;
        digits = d;
        dp_in  = p;
        reset  = r;
        @(posedge clk);
        if (r) begin
            expv  = 32'h0000_0FFF;
            m_n   = 0;
            m_sh  = 0;
            m_psh = '0;
        end else begin
            slot = (m_n / SCAN_DIV) % DIGITS;
            segv = glyph((m_sh >> (4 * slot)) & 32'hF);
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
            if (slot != 0 && (m_sh >> (4 * slot)) == 0) segv = 7'b1111111;
`endif
            expv = {20'd0, ~(4'd1 << slot), segv, ~m_psh[slot]};
            if (m_n % FRAME == FRAME - 1) begin
                m_sh  = d;
                m_psh = p;
            end
            m_n++;
        end
        #1;
        check("scan", {20'd0, an, seg, dp}, expv);
    endtask

    initial begin
        logic [15:0] cur_d;
        logic [3:0]  cur_p;

        reset  = 1'b1;
        digits = '0;
        dp_in  = '0;

        // Reset held
        for (int k = 0; k < 3; k++) tick(16'h0000, 4'h0, 1'b1);
        check("rst_an", {28'd0, an}, 32'hF);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'h1);

        // 1234 for two frames; first edge after release shows zeroed digit 0
        for (int k = 1; k <= 32; k++) begin
            tick(16'h1234, 4'h0, 1'b0);
            if (k == 1) begin
                check("rel_an", {28'd0, an}, 32'hE);
                check("rel_seg", {25'd0, seg}, 32'h40);
            end
            if (k == 17) begin
                check("f2s0_an", {28'd0, an}, 32'hE);
                check("f2s0_seg", {25'd0, seg}, 32'h19);
            end
            if (k == 29) begin
                check("f2s3_an", {28'd0, an}, 32'h7);
                check("f2s3_seg", {25'd0, seg}, 32'h79);
            end
        end

        // Mid-frame change to 9999 during slot 1
        for (int k = 1; k <= 5; k++) tick(16'h1234, 4'h0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            tick(16'h9999, 4'h0, 1'b0);
            if (k == 11) check("old_s3_seg", {25'd0, seg}, 32'h79);
            if (k == 12) check("new_s0_seg", {25'd0, seg}, 32'h10);
        end

        // Dash code and a single decimal point
        for (int j = 1; j <= 32; j++) begin
            tick(16'h00C0, 4'b0010, 1'b0);
            if (j == 17) check("dp_s0", {31'd0, dp}, 32'h1);
            if (j == 20) begin
                check("dash_s1", {25'd0, seg}, 32'h3F);
                check("dp_s1", {31'd0, dp}, 32'h0);
            end
        end

        // Leading zeros
        for (int j = 1; j <= 32; j++) begin
            tick(16'h0050, 4'h0, 1'b0);
            if (j == 16) check("lz_s0", {25'd0, seg}, 32'h40);
            if (j == 20) check("lz_s1", {25'd0, seg}, 32'h12);
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
            if (j == 24) check("lz_s2", {25'd0, seg}, 32'h7F);
            if (j == 28) check("lz_s3", {25'd0, seg}, 32'h7F);
`else
            if (j == 24) check("lz_s2", {25'd0, seg}, 32'h40);
            if (j == 28) check("lz_s3", {25'd0, seg}, 32'h40);
`endif
        end

        // Random digits and decimal points changing at random times
        cur_d = 16'($urandom);
        cur_p = 4'($urandom);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0: cur_d = 16'($urandom);
                    1: cur_d = 16'($urandom_range(0, 255));
                    default: cur_d = 16'($urandom_range(0, 15)) << (4 * $urandom_range(0, 3));
                endcase
                cur_p = 4'($urandom);
            end
            tick(cur_d, cur_p, 1'b0);
        end

        // Asynchronous reset in the middle of slot 2
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (((m_n / SCAN_DIV) % DIGITS) == 2 && (m_n % SCAN_DIV) == 1) break;
            tick(cur_d, cur_p, 1'b0);
        end
        check("reach_s2", {28'd0, an}, 32'hB);
        #1 reset = 1'b1;
        #1;
        check("async_an", {28'd0, an}, 32'hF);
        check("async_seg", {25'd0, seg}, 32'h7F);
        check("async_dp", {31'd0, dp}, 32'h1);
        for (int k = 0; k < 2; k++) tick(cur_d, cur_p, 1'b1);
        tick(cur_d, cur_p, 1'b0);
        check("rest_an", {28'd0, an}, 32'hE);
        check("rest_seg", {25'd0, seg}, 32'h40);
        for (int k = 0; k < 2 * FRAME; k++) tick(cur_d, cur_p, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
